// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync, clock glitch filter, 11-bit frame FSM.
// Optional break-code (F0) ready suppression under macro PS2_BREAK_FILTER_EN.
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ena,
  output logic [7:0] data,
  output logic       ready,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic          ck_s1_q;
  logic          ck_s2_q;
  logic          dt_s1_q;
  logic          dt_s2_q;

  logic          filt_q;
  logic          filt_d;
  logic [3:0]    fcnt_q;
  logic [3:0]    fcnt_d;
  logic          fall;

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    bcnt_q;
  logic [2:0]    bcnt_d;
  logic [7:0]    shreg_q;
  logic [7:0]    shreg_d;
  logic          par_q;
  logic          par_d;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          tmo_hit;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          ready_q;
  logic          ready_d;
  logic          err_q;
  logic          err_d;
  logic          accept;

`ifdef PS2_BREAK_FILTER_EN
  logic          brk_q;
  logic          brk_d;
`endif

  // Pads idle high, so the synchronisers come out of reset at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_s1_q <= 1'b1;
      ck_s2_q <= 1'b1;
      dt_s1_q <= 1'b1;
      dt_s2_q <= 1'b1;
    end else begin
      ck_s1_q <= ps2_clk;
      ck_s2_q <= ck_s1_q;
      dt_s1_q <= ps2_data;
      dt_s2_q <= dt_s1_q;
    end
  end

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (ck_s2_q != filt_q) begin
      if (fcnt_q == 4'(FILTER_LEN - 1)) begin
        filt_d = ck_s2_q;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
  end

  assign fall    = filt_q & ~filt_d;
  assign tmo_hit = (tmo_q + TW'(1)) >= TW'(TIMEOUT_CYC);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    brk_d   = brk_q;
`endif
    if (!ena) begin
      state_d = IDLE;
      bcnt_d  = '0;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall && !dt_s2_q) begin
            state_d = DATA;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          if (fall) begin
            shreg_d = {dt_s2_q, shreg_q[7:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            par_d   = dt_s2_q;
            state_d = STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state_d = IDLE;
            if (dt_s2_q && (^{shreg_q, par_q})) begin
              accept = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A fall in the timeout cycle wins; the counter restarts from it.
      if (!fall && state_q != IDLE && tmo_hit) begin
        state_d = IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else if (state_d == IDLE) begin
        tmo_d = '0;
      end else if (fall) begin
        tmo_d = TW'(1);
      end else begin
        tmo_d = tmo_q + TW'(1);
      end

      if (accept) begin
        data_d = shreg_q;
`ifdef PS2_BREAK_FILTER_EN
        if (brk_q) begin
          brk_d = 1'b0;
        end else if (shreg_q == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
`else
        ready_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      state_q <= IDLE;
      bcnt_q  <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_q <= 1'b0;
    end else begin
      brk_q <= brk_d;
    end
  end
`endif

  assign data  = data_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
